// File: rtl/bus_err_tracker_pkg.sv
// Shared constants and helpers for the bus error tracker.
package bus_err_tracker_pkg;

    localparam int CntWidth = 32;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chan_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_err_tracker_if.sv
// Bus-side signals of the error tracker: per-channel request/response taps and the error FIFO head.
interface bus_err_tracker_if
    import bus_err_tracker_pkg::*;
#(
    parameter int AddrWidth     = 48,
    parameter int MetaDataWidth = 1,
    parameter int ErrBits       = 3,
    parameter int NumChannels   = 2
);
    localparam int ChanW = chan_idx_w(NumChannels);

    logic                                      testmode_i;
    logic [NumChannels-1:0]                    req_valid_i;
    logic [NumChannels-1:0][AddrWidth-1:0]     req_addr_i;
    logic [NumChannels-1:0][MetaDataWidth-1:0] req_meta_i;
    logic [NumChannels-1:0]                    rsp_valid_i;
    logic [NumChannels-1:0]                    rsp_last_i;
    logic [NumChannels-1:0][ErrBits-1:0]       rsp_err_i;
    logic [ErrBits-1:0]                        err_mask_i;
    logic                                      err_valid_o;
    logic                                      err_ready_i;
    logic [AddrWidth-1:0]                      err_addr_o;
    logic [MetaDataWidth-1:0]                  err_meta_o;
    logic [ErrBits-1:0]                        err_code_o;
    logic [ChanW-1:0]                          err_chan_o;
    logic                                      err_orphan_o;
    logic                                      err_overflow_o;
    logic [NumChannels-1:0]                    track_lost_o;
    logic [CntWidth-1:0]                       err_count_o;
    logic                                      cnt_clr_i;
    logic                                      irq_o;

    modport master (
        output testmode_i, req_valid_i, req_addr_i, req_meta_i,
               rsp_valid_i, rsp_last_i, rsp_err_i, err_mask_i,
               err_ready_i, cnt_clr_i,
        input  err_valid_o, err_addr_o, err_meta_o, err_code_o, err_chan_o,
               err_orphan_o, err_overflow_o, track_lost_o, err_count_o, irq_o
    );

    modport slave (
        input  testmode_i, req_valid_i, req_addr_i, req_meta_i,
               rsp_valid_i, rsp_last_i, rsp_err_i, err_mask_i,
               err_ready_i, cnt_clr_i,
        output err_valid_o, err_addr_o, err_meta_o, err_code_o, err_chan_o,
               err_orphan_o, err_overflow_o, track_lost_o, err_count_o, irq_o
    );

endinterface

// File: rtl/bus_err_chan_tracker.sv
// One channel: outstanding-request FIFO, first-error-per-burst flag and capture candidate.
module bus_err_chan_tracker #(
    parameter int AddrWidth      = 48,
    parameter int MetaDataWidth  = 1,
    parameter int ErrBits        = 3,
    parameter int NumOutstanding = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid,
    input  logic [AddrWidth-1:0]     req_addr,
    input  logic [MetaDataWidth-1:0] req_meta,
    input  logic                     rsp_valid,
    input  logic                     rsp_last,
    input  logic [ErrBits-1:0]       rsp_err,
    input  logic [ErrBits-1:0]       err_mask,
    output logic                     cap_valid,
    output logic [AddrWidth-1:0]     cap_addr,
    output logic [MetaDataWidth-1:0] cap_meta,
    output logic [ErrBits-1:0]       cap_code,
    output logic                     cap_orphan,
    output logic                     track_lost
);
    localparam int PtrW = $clog2(NumOutstanding);
    localparam int FillW = PtrW + 1;
    localparam logic [FillW-1:0] Depth = FillW'(NumOutstanding);

    typedef struct packed {
        logic [AddrWidth-1:0]     addr;
        logic [MetaDataWidth-1:0] meta;
    } req_t;

    req_t             req_mem [NumOutstanding];
    logic [PtrW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [FillW-1:0] fill_reg;
    logic             err_seen_reg, lost_reg;
    logic             empty, full, push, pop, err_beat;
    req_t             head;

    assign empty    = (fill_reg == '0);
    assign full     = (fill_reg == Depth);
    assign pop      = rsp_valid && rsp_last && !empty;
    // A full FIFO still accepts a request when the same cycle frees a slot.
    assign push     = req_valid && (!full || pop);
    assign err_beat = rsp_valid && ((rsp_err & ~err_mask) != '0);
    assign head     = req_mem[rd_ptr_reg];

    assign cap_valid  = err_beat && !err_seen_reg;
    assign cap_orphan = empty;
    assign cap_addr   = empty ? '0 : head.addr;
    assign cap_meta   = empty ? '0 : head.meta;
    assign cap_code   = rsp_err;
    assign track_lost = lost_reg;

    always_ff @(posedge clk_i) begin
        if (push) begin
            req_mem[wr_ptr_reg] <= '{addr: req_addr, meta: req_meta};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            err_seen_reg <= 1'b0;
            lost_reg     <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            fill_reg <= fill_reg + FillW'(push) - FillW'(pop);
            if (req_valid && !push) lost_reg <= 1'b1;
            if (rsp_valid && rsp_last) err_seen_reg <= 1'b0;
            else if (cap_valid)        err_seen_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/bus_err_tracker.sv
// Collects the first error of each burst across channels into a shared error FIFO with count and irq.
module bus_err_tracker
    import bus_err_tracker_pkg::*;
#(
    parameter int AddrWidth       = 48,
    parameter int MetaDataWidth   = 1,
    parameter int ErrBits         = 3,
    parameter int NumChannels     = 2,
    parameter int NumOutstanding  = 4,
    parameter int NumStoredErrors = 4,
    parameter int DropOldest      = 0,
    parameter int IrqThreshold    = 1
) (
    input logic              clk_i,
    input logic              rst_ni,
    bus_err_tracker_if.slave bus
);
    localparam int ChanW = chan_idx_w(NumChannels);
    localparam int PtrW  = $clog2(NumStoredErrors);
    localparam int FillW = PtrW + 1;
    localparam logic [FillW-1:0] Depth    = FillW'(NumStoredErrors);
    localparam logic [FillW-1:0] IrqLevel = FillW'(IrqThreshold);
    localparam logic [FillW-1:0] OneLeft  = FillW'(1);
    localparam bit Drop = (DropOldest != 0);

    typedef struct packed {
        logic [AddrWidth-1:0]     addr;
        logic [MetaDataWidth-1:0] meta;
        logic [ErrBits-1:0]       code;
        logic [ChanW-1:0]         chan;
        logic                     orphan;
    } entry_t;

    logic [NumChannels-1:0]   cap_valid, cap_orphan, track_lost;
    logic [AddrWidth-1:0]     cap_addr [NumChannels];
    logic [MetaDataWidth-1:0] cap_meta [NumChannels];
    logic [ErrBits-1:0]       cap_code [NumChannels];

    genvar gi;
    generate
        for (gi = 0; gi < NumChannels; gi++) begin : g_chan
            bus_err_chan_tracker #(
                .AddrWidth     (AddrWidth),
                .MetaDataWidth (MetaDataWidth),
                .ErrBits       (ErrBits),
                .NumOutstanding(NumOutstanding)
            ) u_chan (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .req_valid (bus.req_valid_i[gi]),
                .req_addr  (bus.req_addr_i[gi]),
                .req_meta  (bus.req_meta_i[gi]),
                .rsp_valid (bus.rsp_valid_i[gi]),
                .rsp_last  (bus.rsp_last_i[gi]),
                .rsp_err   (bus.rsp_err_i[gi]),
                .err_mask  (bus.err_mask_i),
                .cap_valid (cap_valid[gi]),
                .cap_addr  (cap_addr[gi]),
                .cap_meta  (cap_meta[gi]),
                .cap_code  (cap_code[gi]),
                .cap_orphan(cap_orphan[gi]),
                .track_lost(track_lost[gi])
            );
        end
    endgenerate

    logic                unused_testmode;
    logic                sel_found, extra_cap;
    entry_t              new_entry;
    logic [CntWidth-1:0] cap_inc;

    assign unused_testmode = bus.testmode_i;

    // Lowest channel index wins the write port; every other capture is a loss.
    always_comb begin
        sel_found = 1'b0;
        extra_cap = 1'b0;
        new_entry = '0;
        cap_inc   = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (cap_valid[c]) begin
                cap_inc = cap_inc + CntWidth'(1);
                if (!sel_found) begin
                    sel_found        = 1'b1;
                    new_entry.addr   = cap_addr[c];
                    new_entry.meta   = cap_meta[c];
                    new_entry.code   = cap_code[c];
                    new_entry.chan   = ChanW'(c);
                    new_entry.orphan = cap_orphan[c];
                end else begin
                    extra_cap = 1'b1;
                end
            end
        end
    end

    entry_t              err_mem [NumStoredErrors];
    logic [PtrW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [FillW-1:0]    fill_reg;
    logic                ovf_reg, irq_reg;
    logic [CntWidth-1:0] cnt_reg;
    logic                head_valid, full, pop, write, overwrite, drop_new, loss, adv_rd;
    logic [CntWidth:0]   cnt_sum;
    entry_t              head;

    assign head_valid = (fill_reg != '0);
    assign full       = (fill_reg == Depth);
    assign pop        = head_valid && bus.err_ready_i;
    assign overwrite  = sel_found && full && !pop && Drop;
    assign drop_new   = sel_found && full && !pop && !Drop;
    assign write      = sel_found && !drop_new;
    assign adv_rd     = pop || overwrite;
    assign loss       = extra_cap || overwrite || drop_new;
    assign cnt_sum    = {1'b0, cnt_reg} + {1'b0, cap_inc};
    assign head       = err_mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (write) begin
            err_mem[wr_ptr_reg] <= new_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
            ovf_reg    <= 1'b0;
            irq_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            if (write)  wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            if (adv_rd) rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            if (write && !adv_rd)      fill_reg <= fill_reg + FillW'(1);
            else if (!write && adv_rd) fill_reg <= fill_reg - FillW'(1);
            if (loss) ovf_reg <= 1'b1;
            else if (pop && !write && fill_reg == OneLeft) ovf_reg <= 1'b0;
            irq_reg <= (fill_reg >= IrqLevel) || ovf_reg;
            if (bus.cnt_clr_i)        cnt_reg <= '0;
            else if (cnt_sum[CntWidth]) cnt_reg <= '1;
            else                      cnt_reg <= cnt_sum[CntWidth-1:0];
        end
    end

    assign bus.err_valid_o    = head_valid;
    assign bus.err_addr_o     = head_valid ? head.addr : '0;
    assign bus.err_meta_o     = head_valid ? head.meta : '0;
    assign bus.err_code_o     = head_valid ? head.code : '0;
    assign bus.err_chan_o     = head_valid ? head.chan : '0;
    assign bus.err_orphan_o   = head_valid && head.orphan;
    assign bus.err_overflow_o = ovf_reg;
    assign bus.track_lost_o   = track_lost;
    assign bus.err_count_o    = cnt_reg;
    assign bus.irq_o          = irq_reg;

endmodule

// File: tb/tb_bus_err_tracker.sv
// Directed bench: two trackers (discard-newest and drop-oldest) driven with identical stimulus.
module tb_bus_err_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req_valid;
    logic [1:0][47:0] req_addr;
    logic [1:0][0:0]  req_meta;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_last;
    logic [1:0][2:0]  rsp_err;
    logic [2:0]       err_mask;
    logic             err_ready;
    logic             cnt_clr;

    int errors = 0;
    int checks = 0;

    logic [2:0] exp0 [4] = '{3'd2, 3'd3, 3'd4, 3'd6};
    logic [2:0] exp1 [4] = '{3'd3, 3'd4, 3'd5, 3'd6};

    bus_err_tracker_if #(.AddrWidth(48), .MetaDataWidth(1), .ErrBits(3), .NumChannels(2)) if0 ();
    bus_err_tracker_if #(.AddrWidth(48), .MetaDataWidth(1), .ErrBits(3), .NumChannels(2)) if1 ();

    assign if0.testmode_i  = 1'b0;
    assign if0.req_valid_i = req_valid;
    assign if0.req_addr_i  = req_addr;
    assign if0.req_meta_i  = req_meta;
    assign if0.rsp_valid_i = rsp_valid;
    assign if0.rsp_last_i  = rsp_last;
    assign if0.rsp_err_i   = rsp_err;
    assign if0.err_mask_i  = err_mask;
    assign if0.err_ready_i = err_ready;
    assign if0.cnt_clr_i   = cnt_clr;

    assign if1.testmode_i  = 1'b1;
    assign if1.req_valid_i = req_valid;
    assign if1.req_addr_i  = req_addr;
    assign if1.req_meta_i  = req_meta;
    assign if1.rsp_valid_i = rsp_valid;
    assign if1.rsp_last_i  = rsp_last;
    assign if1.rsp_err_i   = rsp_err;
    assign if1.err_mask_i  = err_mask;
    assign if1.err_ready_i = err_ready;
    assign if1.cnt_clr_i   = cnt_clr;

    bus_err_tracker #(.DropOldest(0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
    bus_err_tracker #(.DropOldest(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0; req_addr = '0; req_meta = '0;
        rsp_valid = '0; rsp_last = '0; rsp_err = '0;
        err_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pop_one();
        err_ready = 1'b1;
        step();
        err_ready = 1'b0;
    endtask

    initial begin
        idle();
        err_mask = '0;
        step();
        step();
        chk("rst_valid", 64'(if0.err_valid_o), 64'd0);
        chk("rst_count", 64'(if0.err_count_o), 64'd0);
        chk("rst_irq", 64'(if0.irq_o), 64'd0);
        chk("rst_ovf", 64'(if0.err_overflow_o), 64'd0);
        chk("rst_lost", 64'(if0.track_lost_o), 64'd0);
        rst_n = 1'b1;
        step();

        // 3-beat burst, errors on beats 1 and 2: only the first is kept.
        req_valid[0] = 1'b1; req_addr[0] = 48'h1000; req_meta[0] = 1'b1;
        step(); idle();
        rsp_valid[0] = 1'b1; rsp_err[0] = 3'd0;
        step();
        rsp_err[0] = 3'd2;
        step();
        chk("a_valid_n1", 64'(if0.err_valid_o), 64'd1);
        rsp_err[0] = 3'd3; rsp_last[0] = 1'b1;
        step(); idle();
        step();
        chk("a_addr", 64'(if0.err_addr_o), 64'h1000);
        chk("a_meta", 64'(if0.err_meta_o), 64'd1);
        chk("a_code", 64'(if0.err_code_o), 64'd2);
        chk("a_chan", 64'(if0.err_chan_o), 64'd0);
        chk("a_orphan", 64'(if0.err_orphan_o), 64'd0);
        chk("a_count", 64'(if0.err_count_o), 64'd1);
        chk("a_irq", 64'(if0.irq_o), 64'd1);
        pop_one();
        chk("a_popped", 64'(if0.err_valid_o), 64'd0);
        step();
        chk("a_irq_off", 64'(if0.irq_o), 64'd0);

        cnt_clr = 1'b1;
        step(); idle();
        chk("clr_count", 64'(if0.err_count_o), 64'd0);

        // Both channels error in the same cycle.
        req_valid = 2'b11; req_addr[0] = 48'h2000; req_addr[1] = 48'h3000;
        step(); idle();
        rsp_valid = 2'b11; rsp_last = 2'b11; rsp_err[0] = 3'd5; rsp_err[1] = 3'd4;
        step(); idle();
        chk("b_chan", 64'(if0.err_chan_o), 64'd0);
        chk("b_addr", 64'(if0.err_addr_o), 64'h2000);
        chk("b_code", 64'(if0.err_code_o), 64'd5);
        chk("b_ovf", 64'(if0.err_overflow_o), 64'd1);
        chk("b_count", 64'(if0.err_count_o), 64'd2);
        step();
        chk("b_irq", 64'(if0.irq_o), 64'd1);
        pop_one();
        chk("b_empty", 64'(if0.err_valid_o), 64'd0);
        chk("b_ovf_clr", 64'(if0.err_overflow_o), 64'd0);

        // Orphan error on channel 1.
        rsp_valid[1] = 1'b1; rsp_last[1] = 1'b1; rsp_err[1] = 3'd2;
        step(); idle();
        chk("c_valid", 64'(if0.err_valid_o), 64'd1);
        chk("c_orphan", 64'(if0.err_orphan_o), 64'd1);
        chk("c_addr", 64'(if0.err_addr_o), 64'd0);
        chk("c_chan", 64'(if0.err_chan_o), 64'd1);
        pop_one();

        // Masked code 1 is ignored, code 3 still has an unmasked bit.
        err_mask = 3'b001;
        rsp_valid[0] = 1'b1; rsp_last[0] = 1'b1; rsp_err[0] = 3'd1;
        step(); idle();
        chk("d_masked_valid", 64'(if0.err_valid_o), 64'd0);
        chk("d_masked_count", 64'(if0.err_count_o), 64'd3);
        rsp_valid[0] = 1'b1; rsp_last[0] = 1'b1; rsp_err[0] = 3'd3;
        step(); idle();
        chk("d_code", 64'(if0.err_code_o), 64'd3);
        chk("d_count", 64'(if0.err_count_o), 64'd4);
        pop_one();
        err_mask = 3'b000;

        // Five errors without pops, then a push+pop on the full FIFO.
        for (int k = 1; k <= 5; k++) begin
            rsp_valid[0] = 1'b1; rsp_last[0] = 1'b1; rsp_err[0] = 3'(k);
            step();
        end
        idle();
        chk("e_head0", 64'(if0.err_code_o), 64'd1);
        chk("e_head1", 64'(if1.err_code_o), 64'd2);
        chk("e_ovf0", 64'(if0.err_overflow_o), 64'd1);
        chk("e_ovf1", 64'(if1.err_overflow_o), 64'd1);
        rsp_valid[0] = 1'b1; rsp_last[0] = 1'b1; rsp_err[0] = 3'd6; err_ready = 1'b1;
        step(); idle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("e_pop0_%0d", i), 64'(if0.err_code_o), 64'(exp0[i]));
            chk($sformatf("e_pop1_%0d", i), 64'(if1.err_code_o), 64'(exp1[i]));
            chk($sformatf("e_irq_%0d", i), 64'(if0.irq_o), 64'd1);
            pop_one();
        end
        chk("e_empty0", 64'(if0.err_valid_o), 64'd0);
        chk("e_ovf_clr0", 64'(if0.err_overflow_o), 64'd0);
        chk("e_ovf_clr1", 64'(if1.err_overflow_o), 64'd0);
        chk("e_count0", 64'(if0.err_count_o), 64'd10);
        chk("e_count1", 64'(if1.err_count_o), 64'd10);

        // Clear beats a same-cycle increment.
        rsp_valid[0] = 1'b1; rsp_last[0] = 1'b1; rsp_err[0] = 3'd1; cnt_clr = 1'b1;
        step(); idle();
        chk("f_clr_wins", 64'(if0.err_count_o), 64'd0);
        chk("f_captured", 64'(if0.err_valid_o), 64'd1);
        pop_one();

        // Overfill channel 0's request FIFO, open a burst, reset mid-burst.
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1'b1; req_addr[0] = 48'h100 + 48'(k);
            step();
        end
        idle();
        chk("g_lost", 64'(if0.track_lost_o), 64'b01);
        rsp_valid[0] = 1'b1; rsp_err[0] = 3'd2;
        step(); idle();
        chk("g_mid_valid", 64'(if0.err_valid_o), 64'd1);
        chk("g_mid_addr", 64'(if0.err_addr_o), 64'h100);
        rst_n = 1'b0;
        #1;
        chk("g_rst_valid", 64'(if0.err_valid_o), 64'd0);
        chk("g_rst_addr", 64'(if0.err_addr_o), 64'd0);
        chk("g_rst_code", 64'(if0.err_code_o), 64'd0);
        chk("g_rst_meta", 64'(if0.err_meta_o), 64'd0);
        chk("g_rst_orphan", 64'(if0.err_orphan_o), 64'd0);
        chk("g_rst_lost", 64'(if0.track_lost_o), 64'd0);
        chk("g_rst_count", 64'(if0.err_count_o), 64'd0);
        chk("g_rst_irq", 64'(if0.irq_o), 64'd0);
        chk("g_rst_ovf1", 64'(if1.err_overflow_o), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        // Flag and request FIFO were cleared: this beat is a fresh orphan capture.
        rsp_valid[0] = 1'b1; rsp_last[0] = 1'b1; rsp_err[0] = 3'd1;
        step(); idle();
        chk("g_post_valid", 64'(if0.err_valid_o), 64'd1);
        chk("g_post_orphan", 64'(if0.err_orphan_o), 64'd1);
        chk("g_post_addr", 64'(if0.err_addr_o), 64'd0);
        chk("g_post_count", 64'(if0.err_count_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
